cache_arbiter: RTL and testbench

Two-client memory arbiter that sits directly upstream of the cacheline adaptor. It merges instruction-cache line fills and data-cache line fills and writebacks onto the single 256-bit line port of the adaptor. It serialises one whole line transaction at a time and alternates grants when both caches request together. It returns the adaptor's one-cycle response pulse only to the cache that owns the transaction.

---
 rtl/cache_arb_pkg.sv | 32 +++
 rtl/cache_arbiter_chk.sv | 24 ++
 rtl/cache_arbiter.sv | 136 +++++++++++++
 tb/tb_cache_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-client cache line arbiter.
package cache_arb_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BUSY  = 2'd1,
        D_BUSY  = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Two-way round robin: on a tie the client that did not win last time goes next.
    function automatic grant_t rr_pick(input logic i_req, input logic d_req, input grant_t last);
        grant_t pick;
        if (i_req && d_req) begin
            pick = (last == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (i_req) begin
            pick = GRANT_I;
        end else begin
            pick = GRANT_D;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cache_arbiter_chk.sv
// Protocol checks for cache_arbiter: conflicting D-cache ops and stray adaptor responses.
module cache_arbiter_chk
    import cache_arb_pkg::*;
(
    input logic       clk,
    input logic       reset_n,
    input arb_state_t state_i,
    input logic       d_read_i,
    input logic       d_write_i,
    input logic       mem_resp_i
);

    // Flag illegal request combinations and responses with no transaction in flight.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(state_i == IDLE && d_read_i && d_write_i))
                else $warning("cache_arbiter: d_read and d_write both high, serviced as a write");
            assert (!(mem_resp_i && state_i != I_BUSY && state_i != D_BUSY))
                else $warning("cache_arbiter: mem_resp with no transaction in flight, ignored");
        end else begin
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Serialises I-cache fills and D-cache fills/writebacks onto one 256-bit adaptor line port.
module cache_arbiter
    import cache_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_req_s, d_req_s;
    grant_t            pick_s;

    assign i_req_s = i_read;
    assign d_req_s = d_read | d_write;
    assign pick_s  = rr_pick(i_req_s, d_req_s, last_grant_q);

    // State and registered adaptor-side request flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_D;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // Next state: grant in IDLE, hold the request until mem_resp, then one quiet RECOVER cycle.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (i_req_s || d_req_s) begin
                    last_grant_d = pick_s;
                    if (pick_s == GRANT_I) begin
                        state_d       = I_BUSY;
                        mem_read_d    = 1'b1;
                        mem_write_d   = 1'b0;
                        mem_address_d = i_address;
                    end else begin
                        // A conflicting read+write is serviced as a writeback so no dirty line is lost.
                        state_d       = D_BUSY;
                        mem_read_d    = ~d_write;
                        mem_write_d   = d_write;
                        mem_address_d = d_address;
                        mem_wdata_d   = d_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    state_d     = RECOVER;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Route the adaptor's completion pulse only to the transaction owner.
    always_comb begin
        i_resp = 1'b0;
        d_resp = 1'b0;
        case (state_q)
            I_BUSY:  i_resp = mem_resp;
            D_BUSY:  d_resp = mem_resp;
            default: begin
                i_resp = 1'b0;
                d_resp = 1'b0;
            end
        endcase
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

    cache_arbiter_chk u_chk (
        .clk       (clk),
        .reset_n   (reset_n),
        .state_i   (state_q),
        .d_read_i  (d_read),
        .d_write_i (d_write),
        .mem_resp_i(mem_resp)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed and randomized bench for cache_arbiter with a transaction-level owner/turn model.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [31:0]  i_address = 32'd0;
    logic         i_read = 1'b0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_address = 32'd0;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [255:0] d_wdata = 256'd0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = 256'd0;
    logic         mem_resp = 1'b0;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int checks = 0;
    int errors = 0;

    // Model: who owns the line port (0 none, 1 I, 2 D), whose turn it was last, and the quiet gap.
    int           m_owner = 0;
    int           m_last = 2;
    bit           m_gap = 1'b0;
    logic [31:0]  m_addr = 32'd0;
    logic [255:0] m_wdata = 256'd0;
    bit           m_write = 1'b0;

    int           adp_cnt = -1;
    int           adp_lat = 3;
    bit           adp_rand = 1'b0;
    bit           adp_rlat = 1'b0;
    logic [255:0] adp_data = 256'd0;
    bit           force_resp = 1'b0;

    int           i_drop = 0, d_drop = 0, i_extra = 0, d_extra = 0;
    bit           rand_en = 1'b0;
    int           i_resp_cnt = 0, d_resp_cnt = 0, issue_cnt = 0;
    bit           prev_req = 1'b0;
    logic [255:0] last_i_rdata = 256'd0;
    logic [31:0]  obs_addr_q[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_gap = 1'b0;
        adp_cnt = -1; prev_req = 1'b0;
        i_drop = 0; d_drop = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_mem_read", 256'(mem_read), 256'(1'b0));
        chk("rst_mem_write", 256'(mem_write), 256'(1'b0));
        chk("rst_mem_address", 256'(mem_address), 256'(32'd0));
        chk("rst_mem_wdata", mem_wdata, 256'd0);
        chk("rst_i_resp", 256'(i_resp), 256'(1'b0));
        chk("rst_d_resp", 256'(d_resp), 256'(1'b0));
        model_reset();
        mem_resp = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock of bench activity: adaptor drive, response checks, edge, model step, request checks.
    task automatic cycle();
        logic ir, dr, dw, mr;
        logic [31:0] ia, da;
        logic [255:0] dwd;
        int w;
        if (adp_cnt == 0) begin
            mem_resp = 1'b1;
            mem_rdata = adp_rand ? {8{$urandom()}} : adp_data;
            adp_cnt = -1;
        end else begin
            mem_resp = force_resp;
            if (adp_cnt > 0) adp_cnt--;
        end
        #1;
        chk("i_resp", 256'(i_resp), 256'(mem_resp && (m_owner == 1)));
        chk("d_resp", 256'(d_resp), 256'(mem_resp && (m_owner == 2)));
        if (mem_resp) begin
            chk("i_rdata", i_rdata, mem_rdata);
            chk("d_rdata", d_rdata, mem_rdata);
        end
        if (i_resp) begin i_resp_cnt++; i_drop = 1 + i_extra; last_i_rdata = i_rdata; end
        if (d_resp) begin d_resp_cnt++; d_drop = 1 + d_extra; end
        ir = i_read; dr = d_read; dw = d_write; mr = mem_resp;
        ia = i_address; da = d_address; dwd = d_wdata;
        @(posedge clk);
        if (m_owner != 0) begin
            if (mr) begin m_owner = 0; m_gap = 1'b1; end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            w = 0;
            if (ir && (dr || dw)) w = (m_last == 2) ? 1 : 2;
            else if (ir) w = 1;
            else if (dr || dw) w = 2;
            if (w != 0) begin
                m_owner = w; m_last = w;
                if (w == 1) begin m_addr = ia; m_write = 1'b0; end
                else begin m_addr = da; m_write = dw; m_wdata = dwd; end
            end
        end
        #1;
        chk("mem_read", 256'(mem_read), 256'((m_owner == 1) || (m_owner == 2 && !m_write)));
        chk("mem_write", 256'(mem_write), 256'(m_owner == 2 && m_write));
        if (m_owner != 0) chk("mem_address", 256'(mem_address), 256'(m_addr));
        if (m_owner == 2 && m_write) chk("mem_wdata", mem_wdata, m_wdata);
        if ((mem_read || mem_write) && !prev_req) begin
            issue_cnt++;
            obs_addr_q.push_back(mem_address);
        end
        prev_req = mem_read || mem_write;
        if ((mem_read || mem_write) && adp_cnt < 0)
            adp_cnt = adp_rlat ? int'($urandom_range(4)) : adp_lat;
        if (i_drop > 0) begin i_drop--; if (i_drop == 0) i_read = 1'b0; end
        if (d_drop > 0) begin d_drop--; if (d_drop == 0) begin d_read = 1'b0; d_write = 1'b0; end end
        if (rand_en) begin
            if (!i_read && i_drop == 0 && $urandom_range(2) == 0) begin
                i_read = 1'b1; i_address = $urandom() & 32'hFFFF_FFE0; i_extra = int'($urandom_range(1));
            end
            if (!d_read && !d_write && d_drop == 0 && $urandom_range(2) == 0) begin
                w = int'($urandom_range(1));
                d_read = (w == 0); d_write = (w == 1);
                d_address = $urandom() & 32'hFFFF_FFE0; d_wdata = {8{$urandom()}};
                d_extra = int'($urandom_range(1));
            end else if ((d_read || d_write) && $urandom_range(3) == 0) begin
                d_wdata = {8{$urandom()}};
            end
        end
        force_resp = 1'b0;
    endtask

    task automatic run_quiet(input int bound);
        int n;
        n = 0;
        while ((m_owner != 0 || m_gap || i_read || d_read || d_write) && n < bound) begin
            cycle();
            n++;
        end
        chk("quiet_in_budget", 256'(m_owner != 0 || i_read || d_read || d_write), 256'(1'b0));
        cycle();
    endtask

    initial begin
        int i0, d0, n0;
        #1;
        do_reset();

        // I-cache fill only.
        adp_data = {32{8'hA5}}; adp_lat = 3;
        i_read = 1'b1; i_address = 32'h0000_1000; i_extra = 0;
        i0 = i_resp_cnt; d0 = d_resp_cnt;
        cycle();
        chk("i_first_read", 256'(mem_read), 256'(1'b1));
        chk("i_first_addr", 256'(mem_address), 256'(32'h0000_1000));
        run_quiet(40);
        chk("i_resp_count", 256'(i_resp_cnt - i0), 256'(1));
        chk("i_no_d_resp", 256'(d_resp_cnt - d0), 256'(0));
        chk("i_fill_data", last_i_rdata, {32{8'hA5}});

        // D-cache writeback with data changing mid-transaction.
        d0 = d_resp_cnt;
        d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = {8{32'h1234_5678}}; d_extra = 0;
        cycle();
        d_wdata = {8{32'hDEAD_BEEF}};
        cycle();
        chk("d_wdata_latched", mem_wdata, {8{32'h1234_5678}});
        chk("d_write_level", 256'(mem_write), 256'(1'b1));
        run_quiet(40);
        chk("d_resp_count", 256'(d_resp_cnt - d0), 256'(1));

        // Tie right after reset: I first, then D.
        do_reset();
        obs_addr_q.delete();
        i_read = 1'b1; i_address = 32'h0000_1000; i_extra = 0;
        d_read = 1'b1; d_address = 32'h0000_2040; d_extra = 0;
        run_quiet(60);
        chk("tie_issues", 256'(obs_addr_q.size()), 256'(2));
        if (obs_addr_q.size() == 2) begin
            chk("tie_first_I", 256'(obs_addr_q[0]), 256'(32'h0000_1000));
            chk("tie_then_D", 256'(obs_addr_q[1]), 256'(32'h0000_2040));
        end

        // I request held one cycle past its response: RECOVER swallows it.
        n0 = issue_cnt; i0 = i_resp_cnt;
        i_read = 1'b1; i_address = 32'h0000_3000; i_extra = 1;
        run_quiet(40);
        chk("b2b_issues", 256'(issue_cnt - n0), 256'(1));
        chk("b2b_resps", 256'(i_resp_cnt - i0), 256'(1));
        i_extra = 0;

        // Asynchronous reset in the middle of a D transaction.
        adp_lat = 10; d0 = d_resp_cnt;
        d_read = 1'b1; d_address = 32'h0000_4000; d_extra = 0;
        repeat (3) cycle();
        chk("mid_busy", 256'(mem_read), 256'(1'b1));
        mem_resp = 1'b1;
        do_reset();
        chk("mid_no_resp", 256'(d_resp_cnt - d0), 256'(0));
        adp_lat = 2; i0 = i_resp_cnt;
        i_read = 1'b1; i_address = 32'h0000_5000;
        run_quiet(40);
        chk("after_rst_served", 256'(i_resp_cnt - i0), 256'(1));

        // Conflicting D ops become a write; stray response in IDLE reaches nobody.
        d0 = d_resp_cnt;
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_6000; d_wdata = {8{32'hCAFE_F00D}};
        cycle();
        chk("both_is_write", 256'(mem_write), 256'(1'b1));
        chk("both_no_read", 256'(mem_read), 256'(1'b0));
        run_quiet(40);
        chk("both_resp", 256'(d_resp_cnt - d0), 256'(1));
        i0 = i_resp_cnt; d0 = d_resp_cnt;
        force_resp = 1'b1;
        cycle();
        chk("stray_no_i", 256'(i_resp_cnt - i0), 256'(0));
        chk("stray_no_d", 256'(d_resp_cnt - d0), 256'(0));

        // Randomized traffic from both clients against the model.
        adp_rand = 1'b1; adp_rlat = 1'b1; rand_en = 1'b1;
        repeat (600) cycle();
        rand_en = 1'b0;
        run_quiet(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
